syst_ws_ctrl: RTL and testbench

SYST_WS_CTRL -- requirements
Module: syst_ws_ctrl

---
 rtl/syst_ws_ctrl.sv | 162 ++++++++++++++++
 tb/tb_syst_ws_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/syst_ws_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : syst_ws_ctrl
// Purpose  : Skews input vectors into a 3-input weight-stationary array and
//            realigns its two outputs into one tagged result stream per frame.
// Revision : 1.0
// ============================================================================
module syst_ws_ctrl #(
    parameter int X_W       = 8,
    parameter int Y_W       = 19,
    parameter int ARRAY_LAT = 3,
    parameter int Y2_OFS    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [X_W-1:0]   s_a1_i,
    input  logic [X_W-1:0]   s_a2_i,
    input  logic [X_W-1:0]   s_a3_i,
    input  logic             s_last_i,
    output logic [X_W-1:0]   x1_o,
    output logic [X_W-1:0]   x2_o,
    output logic [X_W-1:0]   x3_o,
    input  logic [Y_W-1:0]   y1_i,
    input  logic [Y_W-1:0]   y2_i,
    output logic             m_valid_o,
    output logic [Y_W-1:0]   m_y1_o,
    output logic [Y_W-1:0]   m_y2_o,
    output logic             m_last_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] vec_cnt_o
);

    localparam int TAG_D = 2 + ARRAY_LAT + Y2_OFS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rdy_en_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs;

    logic [X_W-1:0]   x1_q, a2_q, x2_q, a3_q1, a3_q2, x3_q;
    logic [TAG_D-1:0] vld_q, last_q;
    logic [Y_W-1:0]   m_y1_q, m_y2_q;
    logic [Y_W-1:0]   y1_aligned;

    // Ready stays low through reset and rises on the first edge after release.
    assign s_ready_o = rdy_en_q && (state_q != ST_DRAIN);
    assign hs        = s_valid_i && s_ready_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs) state_d = s_last_i ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (hs && s_last_i) state_d = ST_DRAIN;
            ST_DRAIN: if (frame_done_o) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ST_IDLE && state_d == ST_IDLE)
            cnt_d = '0;
        else if (hs && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rdy_en_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            cnt_q    <= cnt_d;
        end
    end

    // Lane k is delayed k cycles; slots without a handshake carry zeros.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x1_q  <= '0;
            a2_q  <= '0;
            x2_q  <= '0;
            a3_q1 <= '0;
            a3_q2 <= '0;
            x3_q  <= '0;
        end else begin
            x1_q  <= hs ? s_a1_i : '0;
            a2_q  <= hs ? s_a2_i : '0;
            x2_q  <= a2_q;
            a3_q1 <= hs ? s_a3_i : '0;
            a3_q2 <= a3_q1;
            x3_q  <= a3_q2;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= {vld_q[TAG_D-2:0], hs};
            last_q <= {last_q[TAG_D-2:0], hs && s_last_i};
        end
    end

    generate
        if (Y2_OFS == 0) begin : g_y1_pass
            assign y1_aligned = y1_i;
        end else begin : g_y1_dly
            logic [Y_W-1:0] y1_dly_q [Y2_OFS];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < Y2_OFS; i++) y1_dly_q[i] <= '0;
                end else begin
                    y1_dly_q[0] <= y1_i;
                    for (int i = 1; i < Y2_OFS; i++) y1_dly_q[i] <= y1_dly_q[i-1];
                end
            end
            assign y1_aligned = y1_dly_q[Y2_OFS-1];
        end
    endgenerate

    // The result register loads in the cycle y2 of a tagged slot is present.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_y1_q <= '0;
            m_y2_q <= '0;
        end else if (vld_q[TAG_D-2]) begin
            m_y1_q <= y1_aligned;
            m_y2_q <= y2_i;
        end else begin
            m_y1_q <= '0;
            m_y2_q <= '0;
        end
    end

    assign x1_o         = x1_q;
    assign x2_o         = x2_q;
    assign x3_o         = x3_q;
    assign m_valid_o    = vld_q[TAG_D-1];
    assign m_last_o     = last_q[TAG_D-1];
    assign frame_done_o = vld_q[TAG_D-1] && last_q[TAG_D-1];
    assign m_y1_o       = m_y1_q;
    assign m_y2_o       = m_y2_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign vec_cnt_o    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_syst_ws_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_syst_ws_ctrl
// Purpose  : Randomized self-checking bench for syst_ws_ctrl with a 2x3
//            weight-stationary array model driving the y inputs.
// Revision : 1.0
// ============================================================================
module tb_syst_ws_ctrl;

    localparam int X_W = 8, Y_W = 19, AL = 3, Y2 = 1, CNT_W = 3;
    localparam int D = 2 + AL + Y2;
    localparam int N = 4096;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             s_valid_i = 1'b0, s_last_i = 1'b0;
    logic [X_W-1:0]   s_a1_i = '0, s_a2_i = '0, s_a3_i = '0;
    logic             s_ready_o;
    logic [X_W-1:0]   x1_o, x2_o, x3_o;
    logic [Y_W-1:0]   y1_i = '0, y2_i = '0;
    logic             m_valid_o, m_last_o, busy_o, frame_done_o;
    logic [Y_W-1:0]   m_y1_o, m_y2_o;
    logic [CNT_W-1:0] vec_cnt_o;

    syst_ws_ctrl #(.X_W(X_W), .Y_W(Y_W), .ARRAY_LAT(AL), .Y2_OFS(Y2), .CNT_W(CNT_W)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .s_a1_i(s_a1_i), .s_a2_i(s_a2_i), .s_a3_i(s_a3_i), .s_last_i(s_last_i),
        .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o),
        .y1_i(y1_i), .y2_i(y2_i),
        .m_valid_o(m_valid_o), .m_y1_o(m_y1_o), .m_y2_o(m_y2_o), .m_last_o(m_last_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .vec_cnt_o(vec_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    // Array weights: row 0 feeds y1, row 1 feeds y2.
    int W [2][3] = '{'{3, 5, 7}, '{2, 4, 6}};

    logic [X_W-1:0] xh1 [N], xh2 [N], xh3 [N];
    logic [X_W-1:0] exp_x1 [N], exp_x2 [N], exp_x3 [N];
    bit             exp_v [N], exp_l [N];
    logic [Y_W-1:0] exp_y1 [N], exp_y2 [N];

    bit m_ready = 1'b0, m_busy = 1'b0;
    int m_cnt = 0, done_at = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lane_x(input int j, input int idx);
        if (idx < 0 || idx >= N) return 0;
        case (j)
            0: return int'(xh1[idx]);
            1: return int'(xh2[idx]);
            default: return int'(xh3[idx]);
        endcase
    endfunction

    // Behavioural array: each output row sums weighted lanes seen along its diagonal.
    function automatic logic [Y_W-1:0] arr_y(input int k, input int row);
        int base = k - AL - ((row == 1) ? Y2 : 0);
        int s = 0;
        for (int j = 0; j < 3; j++) s += W[row][j] * lane_x(j, base + j);
        return Y_W'(s);
    endfunction

    function automatic logic [Y_W-1:0] dot(input int row, input int a1, input int a2, input int a3);
        return Y_W'(W[row][0] * a1 + W[row][1] * a2 + W[row][2] * a3);
    endfunction

    task automatic step(input bit v, input int a1, input int a2, input int a3, input bit last);
        int k;
        bit hs;
        @(negedge clk_i);
        k = cyc;
        if (k + D + 2 >= N) begin
            $display("FAIL cycle_budget cyc=%0d got=overrun exp=<%0d", k, N);
            $fatal(1);
        end
        xh1[k] = x1_o; xh2[k] = x2_o; xh3[k] = x3_o;
        chk("ready", 32'(s_ready_o), 32'(m_ready));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("vec_cnt", 32'(vec_cnt_o), 32'(m_cnt));
        chk("x1", 32'(x1_o), 32'(exp_x1[k]));
        chk("x2", 32'(x2_o), 32'(exp_x2[k]));
        chk("x3", 32'(x3_o), 32'(exp_x3[k]));
        chk("m_valid", 32'(m_valid_o), 32'(exp_v[k]));
        chk("m_last", 32'(m_last_o), 32'(exp_l[k]));
        chk("frame_done", 32'(frame_done_o), 32'(exp_l[k]));
        if (exp_v[k]) begin
            chk("m_y1", 32'(m_y1_o), 32'(exp_y1[k]));
            chk("m_y2", 32'(m_y2_o), 32'(exp_y2[k]));
        end
        y1_i = arr_y(k, 0);
        y2_i = arr_y(k, 1);
        s_valid_i = v; s_last_i = last;
        s_a1_i = X_W'(a1); s_a2_i = X_W'(a2); s_a3_i = X_W'(a3);
        hs = v && m_ready;
        if (hs) begin
            exp_x1[k+1] = X_W'(a1);
            exp_x2[k+2] = X_W'(a2);
            exp_x3[k+3] = X_W'(a3);
            exp_v[k+D]  = 1'b1;
            exp_l[k+D]  = last;
            exp_y1[k+D] = dot(0, a1 & 255, a2 & 255, a3 & 255);
            exp_y2[k+D] = dot(1, a1 & 255, a2 & 255, a3 & 255);
            m_busy = 1'b1;
            if (m_cnt != (1 << CNT_W) - 1) m_cnt++;
            if (last) begin
                m_ready = 1'b0;
                done_at = k + D;
            end
        end
        if (done_at == k) begin
            m_busy = 1'b0; m_ready = 1'b1; m_cnt = 0; done_at = -1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    // Runs until the frame closes; optionally holds random valid vectors during the drain.
    task automatic finish_frame(input bit hold_valid);
        for (int i = 0; i < 4 * D && !m_ready; i++)
            step(hold_valid, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b1);
        chk("frame_closes", 32'(m_ready), 32'(1));
    endtask

    task automatic do_reset(input int hold);
        int k;
        @(negedge clk_i);
        rst_i = 1'b1; s_valid_i = 1'b0; s_last_i = 1'b0; y1_i = '0; y2_i = '0;
        #1;
        k = cyc;
        chk("rst_x1", 32'(x1_o), 0);
        chk("rst_x2", 32'(x2_o), 0);
        chk("rst_x3", 32'(x3_o), 0);
        chk("rst_m_valid", 32'(m_valid_o), 0);
        chk("rst_m_last", 32'(m_last_o), 0);
        chk("rst_frame_done", 32'(frame_done_o), 0);
        chk("rst_m_y1", 32'(m_y1_o), 0);
        chk("rst_m_y2", 32'(m_y2_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_cnt", 32'(vec_cnt_o), 0);
        chk("rst_ready", 32'(s_ready_o), 0);
        for (int i = k; i < N; i++) begin
            exp_x1[i] = '0; exp_x2[i] = '0; exp_x3[i] = '0;
            exp_v[i] = 1'b0; exp_l[i] = 1'b0; exp_y1[i] = '0; exp_y2[i] = '0;
        end
        xh1[k] = '0; xh2[k] = '0; xh3[k] = '0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            xh1[cyc] = '0; xh2[cyc] = '0; xh3[cyc] = '0;
            chk("ready_in_rst", 32'(s_ready_o), 0);
        end
        rst_i = 1'b0;
        m_ready = 1'b1; m_busy = 1'b0; m_cnt = 0; done_at = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        int len;
        for (int i = 0; i < N; i++) begin
            xh1[i] = '0; xh2[i] = '0; xh3[i] = '0;
        end
        do_reset(2);

        // Single-vector frame.
        step(1'b1, 1, 2, 3, 1'b1);
        idle(8);

        // Three back-to-back vectors.
        step(1'b1, 1, 0, 0, 1'b0);
        step(1'b1, 2, 2, 0, 1'b0);
        step(1'b1, 3, 4, 3, 1'b1);
        idle(9);

        // Bubble between two vectors.
        step(1'b1, 9, 8, 7, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 4, 5, 6, 1'b1);
        idle(9);

        // Valid held through the drain; next frame starts on the first ready cycle.
        step(1'b1, 5, 6, 7, 1'b1);
        finish_frame(1'b1);
        step(1'b1, 8, 9, 10, 1'b1);
        finish_frame(1'b0);
        idle(2);

        // Counter saturation with a long frame.
        for (int i = 0; i < 9; i++) step(1'b1, i + 1, 2 * i, 255 - i, i == 8);
        finish_frame(1'b0);
        idle(2);

        // Reset with two vectors in flight, then a clean single-vector frame.
        step(1'b1, 11, 12, 13, 1'b0);
        step(1'b1, 14, 15, 16, 1'b0);
        do_reset(2);
        idle(10);
        step(1'b1, 1, 2, 3, 1'b1);
        idle(8);

        // Random frames against the array model.
        void'($urandom(147));
        for (int f = 0; f < 4; f++) begin
            len = (f == 0) ? 5 : int'($urandom_range(1, 6));
            for (int v = 0; v < len; v++) begin
                if ($urandom_range(0, 2) == 0) step(1'b0, 0, 0, 0, 1'b0);
                step(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), v == len - 1);
            end
            finish_frame(f[0]);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
